// File: rtl/instr_decode_stage_pkg.sv
// rtl/instr_decode_stage_pkg.sv - shared opcode, aluop, condition and decoded-bundle types
package instr_decode_stage_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 25;
    localparam int RD_MSB  = 24;
    localparam int RD_LSB  = 20;
    localparam int RS1_MSB = 19;
    localparam int RS1_LSB = 15;
    localparam int RS2_MSB = 14;
    localparam int RS2_LSB = 10;
    localparam int IMM_I_MSB = 14;
    localparam int IMM_B_MSB = 24;

    // Register/immediate ALU pairs sit at even/odd codes so op[6:1] is the aluop.
    typedef enum logic [6:0] {
        OP_ADD  = 7'h00, OP_ADDI = 7'h01, OP_SUB  = 7'h02, OP_SUBI = 7'h03,
        OP_MUL  = 7'h04, OP_MULI = 7'h05, OP_DIV  = 7'h06, OP_DIVI = 7'h07,
        OP_CMP  = 7'h08, OP_CMPI = 7'h09, OP_AND  = 7'h0A, OP_ANDI = 7'h0B,
        OP_OR   = 7'h0C, OP_ORI  = 7'h0D, OP_XOR  = 7'h0E, OP_XORI = 7'h0F,
        OP_LSL  = 7'h10, OP_LSLI = 7'h11, OP_LSR  = 7'h12, OP_LSRI = 7'h13,
        OP_MOV  = 7'h14, OP_MOVI = 7'h15, OP_NOT  = 7'h16, OP_LDR  = 7'h17,
        OP_STR  = 7'h18, OP_BR   = 7'h19, OP_B    = 7'h1A, OP_BEQ  = 7'h1B,
        OP_BNE  = 7'h1C, OP_BGT  = 7'h1D, OP_BGE  = 7'h1E, OP_BLT  = 7'h1F,
        OP_BLE  = 7'h20, OP_BREQ = 7'h21, OP_BRNE = 7'h22, OP_BRGT = 7'h23,
        OP_BRGE = 7'h24, OP_BRLT = 7'h25, OP_BRLE = 7'h26
    } opcode_t;

    typedef enum logic [5:0] {
        ALU_ADD = 6'd0, ALU_SUB = 6'd1, ALU_MUL = 6'd2,  ALU_DIV = 6'd3,
        ALU_CMP = 6'd4, ALU_AND = 6'd5, ALU_OR  = 6'd6,  ALU_XOR = 6'd7,
        ALU_LSL = 6'd8, ALU_LSR = 6'd9, ALU_MOV = 6'd10, ALU_NOT = 6'd11,
        ALU_B   = 6'd12, ALU_BR = 6'd13
    } aluop_t;

    typedef enum logic [2:0] {
        COND_AL = 3'd0, COND_EQ = 3'd1, COND_NE = 3'd2, COND_GT = 3'd3,
        COND_GE = 3'd4, COND_LT = 3'd5, COND_LE = 3'd6
    } cond_t;

    typedef struct packed {
        aluop_t            aluop;
        cond_t             cond;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [XLEN-1:0]   imm;
        logic              use_imm;
        logic              reg_we;
        logic              mem_rd;
        logic              mem_wr;
        logic              branch;
        logic              illegal;
    } decoded_t;

endpackage

// File: rtl/instr_decode_stage_comb.sv
// rtl/instr_decode_stage_comb.sv - combinational instruction word to decoded bundle
module instr_decode_comb
    import instr_decode_stage_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output decoded_t        dec
);

    logic [6:0]        op;
    logic [REG_AW-1:0] f_rd;
    logic [REG_AW-1:0] f_rs1;
    logic [REG_AW-1:0] f_rs2;
    logic [XLEN-1:0]   imm_i;
    logic [XLEN-1:0]   imm_b;

    assign op    = instr[OP_MSB:OP_LSB];
    assign f_rd  = instr[RD_MSB:RD_LSB];
    assign f_rs1 = instr[RS1_MSB:RS1_LSB];
    assign f_rs2 = instr[RS2_MSB:RS2_LSB];
    assign imm_i = {{(XLEN-IMM_I_MSB-1){instr[IMM_I_MSB]}}, instr[IMM_I_MSB:0]};
    assign imm_b = {{(XLEN-IMM_B_MSB-1){instr[IMM_B_MSB]}}, instr[IMM_B_MSB:0]};

    always_comb begin
        dec = '0;
        if (op <= OP_MOVI) begin
            dec.aluop   = aluop_t'(op[6:1]);
            dec.use_imm = op[0];
            dec.rd      = f_rd;
            dec.rs1     = f_rs1;
            dec.reg_we  = (op[6:1] != 6'(ALU_CMP));
            if (op[0]) dec.imm = imm_i;
            else       dec.rs2 = f_rs2;
        end else begin
            case (op)
                OP_NOT: begin
                    dec.aluop  = ALU_NOT;
                    dec.rd     = f_rd;
                    dec.rs1    = f_rs1;
                    dec.reg_we = 1'b1;
                end
                OP_LDR: begin
                    dec.aluop   = ALU_ADD;
                    dec.rd      = f_rd;
                    dec.rs1     = f_rs1;
                    dec.imm     = imm_i;
                    dec.use_imm = 1'b1;
                    dec.reg_we  = 1'b1;
                    dec.mem_rd  = 1'b1;
                end
                OP_STR: begin
                    // store-data register lives in the rd field but is read, so it goes out on rs2
                    dec.aluop   = ALU_ADD;
                    dec.rs1     = f_rs1;
                    dec.rs2     = f_rd;
                    dec.imm     = imm_i;
                    dec.use_imm = 1'b1;
                    dec.mem_wr  = 1'b1;
                end
                OP_BR: begin
                    dec.aluop  = ALU_BR;
                    dec.cond   = COND_AL;
                    dec.rs1    = f_rs1;
                    dec.branch = 1'b1;
                end
                default: begin
                    if (op >= OP_B && op <= OP_BLE) begin
                        dec.aluop  = ALU_B;
                        dec.cond   = cond_t'(3'(op - OP_B));
                        dec.imm    = imm_b;
                        dec.branch = 1'b1;
                    end else if (op >= OP_BREQ && op <= OP_BRLE) begin
                        dec.aluop  = ALU_BR;
                        dec.cond   = cond_t'(3'(op - OP_BREQ + 7'd1));
                        dec.rs1    = f_rs1;
                        dec.branch = 1'b1;
                    end else begin
                        dec.illegal = 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - decode stage with registered output and one-entry skid buffer
module instr_decode_stage
    import instr_decode_stage_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [5:0]        out_aluop,
    output logic [2:0]        out_cond,
    output logic [REG_AW-1:0] out_rd,
    output logic [REG_AW-1:0] out_rs1,
    output logic [REG_AW-1:0] out_rs2,
    output logic [XLEN-1:0]   out_imm,
    output logic              out_use_imm,
    output logic              out_reg_we,
    output logic              out_mem_rd,
    output logic              out_mem_wr,
    output logic              out_branch,
    output logic              out_illegal
);

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

    state_t          state, state_nxt;
    decoded_t        in_dec, out_dec, skid_dec;
    logic [XLEN-1:0] skid_pc;
    logic            accept, drain;
    logic            load_out, load_skid, out_from_skid;

    instr_decode_comb u_comb (
        .instr (in_instr),
        .dec   (in_dec)
    );

    assign out_valid = (state != ST_EMPTY);
    assign in_ready  = (state != ST_FULL);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_nxt     = state;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        case (state)
            ST_EMPTY: if (accept) begin
                state_nxt = ST_ONE;
                load_out  = 1'b1;
            end
            ST_ONE: begin
                if (accept && drain) begin
                    load_out = 1'b1;
                end else if (drain) begin
                    state_nxt = ST_EMPTY;
                end else if (accept) begin
                    state_nxt = ST_FULL;
                    load_skid = 1'b1;
                end
            end
            ST_FULL: if (drain) begin
                state_nxt     = ST_ONE;
                load_out      = 1'b1;
                out_from_skid = 1'b1;
            end
            default: state_nxt = ST_EMPTY;
        endcase
        if (flush) begin
            state_nxt = ST_EMPTY;
            load_out  = 1'b0;
            load_skid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= ST_EMPTY;
            out_pc   <= '0;
            out_dec  <= '0;
            skid_pc  <= '0;
            skid_dec <= '0;
        end else begin
            state <= state_nxt;
            if (load_out) begin
                out_pc  <= out_from_skid ? skid_pc  : in_pc;
                out_dec <= out_from_skid ? skid_dec : in_dec;
            end
            if (load_skid) begin
                skid_pc  <= in_pc;
                skid_dec <= in_dec;
            end
        end
    end

    assign out_aluop   = out_dec.aluop;
    assign out_cond    = out_dec.cond;
    assign out_rd      = out_dec.rd;
    assign out_rs1     = out_dec.rs1;
    assign out_rs2     = out_dec.rs2;
    assign out_imm     = out_dec.imm;
    assign out_use_imm = out_dec.use_imm;
    assign out_reg_we  = out_dec.reg_we;
    assign out_mem_rd  = out_dec.mem_rd;
    assign out_mem_wr  = out_dec.mem_wr;
    assign out_branch  = out_dec.branch;
    assign out_illegal = out_dec.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - directed self-checking bench for instr_decode_stage
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        n_rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, out_imm;
    logic [5:0]  out_aluop;
    logic [2:0]  out_cond;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic        out_use_imm, out_reg_we, out_mem_rd, out_mem_wr, out_branch, out_illegal;

    int errors = 0;
    int checks = 0;

    instr_decode_stage dut (
        .clk(clk), .n_rst(n_rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_aluop(out_aluop), .out_cond(out_cond),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .out_use_imm(out_use_imm), .out_reg_we(out_reg_we), .out_mem_rd(out_mem_rd),
        .out_mem_wr(out_mem_wr), .out_branch(out_branch), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_instr = instr;
        in_pc    = pc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_pc", out_pc, 0);
        chk("rst_imm", out_imm, 0);
        chk("rst_ctl", {out_use_imm, out_reg_we, out_mem_rd, out_mem_wr, out_branch, out_illegal}, 0);
        n_rst = 1'b1;
        out_ready = 1'b1;

        send(32'h0230FFFF, 32'h100);
        chk("addi_valid", out_valid, 1);
        chk("addi_pc", out_pc, 32'h100);
        chk("addi_aluop", out_aluop, 0);
        chk("addi_rd", out_rd, 3);
        chk("addi_rs1", out_rs1, 1);
        chk("addi_imm", out_imm, 32'hFFFFFFFF);
        chk("addi_use_imm", out_use_imm, 1);
        chk("addi_reg_we", out_reg_we, 1);

        send(32'h37FFFFFC, 32'h104);
        chk("beq_branch", out_branch, 1);
        chk("beq_cond", out_cond, 1);
        chk("beq_aluop", out_aluop, 12);
        chk("beq_imm", out_imm, 32'hFFFFFFFC);
        chk("beq_reg_we", out_reg_we, 0);

        send(32'h10000000, 32'h108);
        chk("cmp_aluop", out_aluop, 4);
        chk("cmp_reg_we", out_reg_we, 0);

        send(32'hFE000000, 32'h10C);
        chk("ill_valid", out_valid, 1);
        chk("ill_flag", out_illegal, 1);
        chk("ill_ctl", {out_reg_we, out_mem_wr, out_mem_rd, out_branch}, 0);
        chk("ill_aluop_rd", {out_aluop, out_rd}, 0);

        send(32'h2E220010, 32'h110);
        chk("ldr_ctl", {out_mem_rd, out_mem_wr, out_reg_we, out_use_imm}, 4'b1011);
        chk("ldr_regs", {out_rd, out_rs1}, {5'd2, 5'd4});
        chk("ldr_imm", out_imm, 32'h10);

        send(32'h30537FF8, 32'h114);
        chk("str_ctl", {out_mem_rd, out_mem_wr, out_reg_we}, 3'b010);
        chk("str_regs", {out_rd, out_rs1, out_rs2}, {5'd0, 5'd6, 5'd5});
        chk("str_imm", out_imm, 32'hFFFFFFF8);

        send(32'h32038000, 32'h118);
        chk("br_aluop", out_aluop, 13);
        chk("br_fields", {out_cond, out_rs1, out_branch}, {3'd0, 5'd7, 1'b1});
        chk("br_imm", out_imm, 0);

        tick();
        chk("drain_empty", out_valid, 0);

        // backpressure: A and B held, C waits at the input
        out_ready = 1'b0;
        send(32'h00100000, 32'h200);
        chk("bp_a_valid", out_valid, 1);
        chk("bp_a_ready", in_ready, 1);
        send(32'h00200000, 32'h204);
        chk("bp_full_ready", in_ready, 0);
        chk("bp_hold_a", out_pc, 32'h200);
        in_instr = 32'h00300000; in_pc = 32'h208; in_valid = 1'b1;
        tick();
        chk("bp_stable_pc", out_pc, 32'h200);
        chk("bp_stable_rd", out_rd, 1);
        out_ready = 1'b1;
        tick();
        chk("bp_b_pc", out_pc, 32'h204);
        chk("bp_b_rd", out_rd, 2);
        chk("bp_b_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_c_pc", out_pc, 32'h208);
        chk("bp_c_rd", out_rd, 3);
        tick();
        chk("bp_done", out_valid, 0);

        // flush while FULL with a new word presented
        out_ready = 1'b0;
        send(32'h00100000, 32'h300);
        send(32'h00200000, 32'h304);
        chk("fl_full", in_ready, 0);
        in_instr = 32'h00300000; in_pc = 32'h308; in_valid = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        out_ready = 1'b1;
        tick(); tick();
        chk("fl_no_ghost", out_valid, 0);

        // asynchronous reset mid-stall
        out_ready = 1'b0;
        send(32'h00100000, 32'h380);
        send(32'h00200000, 32'h384);
        chk("ar_full", in_ready, 0);
        #2 n_rst = 1'b0;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_in_ready", in_ready, 1);
        chk("ar_pc", out_pc, 0);
        tick();
        n_rst = 1'b1;
        out_ready = 1'b1;
        send(32'h0230FFFF, 32'h400);
        chk("ar_resume_pc", out_pc, 32'h400);
        chk("ar_resume_dec", {out_aluop, out_rd, out_rs1}, {6'd0, 5'd3, 5'd1});
        chk("ar_resume_imm", out_imm, 32'hFFFFFFFF);
        tick();
        chk("ar_resume_drain", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
